mem_arbiter: RTL
================

# mem_arbiter

Arbitrates a single-ported, multi-cycle main memory between the instruction-fetch stage (read-only I port) and the memory stage (read/write D port) of the five-stage pipeline. Only one transaction is outstanding at the memory at any time. Simultaneous requests are granted round-robin. An I-side cancel lets a branch flush discard an in-flight fetch without disturbing memory sequencing.

## Interface
- ADDR_W, 16, address width (byte address, word aligned)
- DATA_W, 16, data word width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request; held until i_ack or i_cancel
- i_addr  in  ADDR_W  fetch address
- i_cancel  in  1  flush: drop the current or pending I transaction
- i_ack  out  1  one-cycle pulse: i_rdata is valid
- i_rdata  out  DATA_W  fetched word (registered)
- d_req  in  1  data request; held until d_ack
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: read data valid or write complete
- d_rdata  out  DATA_W  read word (registered; unchanged on writes)
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  ADDR_W  issued address
- mem_wdata  out  DATA_W  issued write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_valid
- mem_valid  in  1  one-cycle completion pulse from memory, at least 1 cycle after mem_en
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. An owner register (I or D) and a last_owner register (reset value I) support arbitration.
- IDLE: I is eligible when i_req=1 and i_cancel=0. D is eligible when d_req=1.
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port that is not last_owner is granted.
  - On grant, the arbiter latches addr, wr, and wdata (wr=0 and wdata=0 for I), sets owner and last_owner, and moves to ISSUE.
  - If neither port is eligible, the FSM stays in IDLE.
- ISSUE: mem_en=1 and mem_wr, mem_addr, and mem_wdata come from the latched registers. The FSM always moves to WAIT.
- WAIT: the FSM holds until mem_valid=1.
  - On a read, mem_rdata is captured into i_rdata or d_rdata according to owner.
  - The FSM then moves to DONE.
- DONE:
  - Owner D: d_ack=1.
  - Owner I: i_ack = ~cancel_flag & ~i_cancel.
  - The FSM always returns to IDLE.
- cancel_flag is set by i_cancel=1 in any cycle while owner=I and the state is ISSUE, WAIT, or DONE. It is cleared on entry to IDLE.
  - A cancelled fetch still completes at the memory, because the memory cannot abort.
  - i_rdata is still updated, but no i_ack is given.
- i_cancel has no effect on a D transaction.
- mem_valid is ignored in IDLE, ISSUE, and DONE.
- Requesters deassert req on the cycle after ack. The arbiter does not re-sample req in DONE.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, owner=I, last_owner=I, cancel_flag=0, and all outputs 0 (including i_rdata and d_rdata).
- Reset asserted mid-transaction returns the FSM to IDLE on the next edge. A late mem_valid that arrives afterwards is ignored.
- Latency: request sampled in IDLE at cycle t, mem_en at t+1, mem_valid at t+1+L (L ≥ 1), ack at t+2+L, IDLE at t+3+L.
  - The minimum request-to-ack latency is 3 cycles.
  - The earliest next grant is at t+3+L.
- mem_en is high for exactly one cycle per transaction and never while a transaction is outstanding.
- mem_addr, mem_wr, and mem_wdata are stable from ISSUE through DONE.
- At most one of i_ack and d_ack is high in any cycle.
- Back-to-back contention strictly alternates D, I, D, I, and so on. No port is starved.

## Test plan
- Single fetch, L=1: i_req with i_addr=0x0010 and memory returning 0xA5A5 → mem_en pulse at t+1 with addr 0x0010 and mem_wr=0; i_ack at t+3 with i_rdata=0xA5A5; busy is high for cycles t+1 to t+3.
- Data write then read, L=4: write d_addr=0x0100 with d_wdata=0x1234, then read 0x0100 → write: mem_wr=1 and d_ack at t+6 with d_rdata unchanged (0); read: d_rdata=0x1234.
- Contention: i_req and d_req held continuously from reset, each deasserting for one cycle after its ack → grant order D, I, D, I; mem_en never overlaps an outstanding transaction.
- Flush: i_cancel pulsed during WAIT of a fetch to 0x0020 → memory still completes; no i_ack; FSM returns to IDLE; a subsequent fetch to 0x0030 is acknowledged normally.
- Reset in WAIT: rst asserted for 1 cycle, then mem_valid arrives → all outputs 0 and state IDLE; the stray mem_valid produces no ack; the next request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported, multi-cycle memory between the instruction
//   fetch port (I, read-only) and the memory-stage port (D, read/write).
//   Only one transaction is outstanding at the memory at a time. When both
//   ports ask at once, the port that was not served last is granted. A
//   fetch can be cancelled by a branch flush. The memory still finishes the
//   access, but no i_ack is given for it.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   i_req/i_addr          fetch request and address (held until ack/cancel)
//   i_cancel              flush of the current or pending fetch
//   i_ack/i_rdata         one-cycle fetch completion, registered read word
//   d_req/d_wr/d_addr/
//   d_wdata               data request, held until d_ack
//   d_ack/d_rdata         one-cycle data completion, registered read word
//   mem_en/mem_wr/
//   mem_addr/mem_wdata    issue strobe and latched command to memory
//   mem_rdata/mem_valid   memory completion pulse with read data
//   busy                  high whenever a transaction is in progress
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t            state;
    state_t            state_nx;
    owner_t            owner;
    owner_t            last_owner;
    logic              cancel_flag;
    logic              i_elig;
    logic              d_elig;
    logic              grant_i;
    logic              grant_d;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    always_comb begin
        state_nx = state;
        i_elig   = i_req & ~i_cancel;
        d_elig   = d_req;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        case (state)
            S_IDLE: begin
                // On a tie, D wins only when I was the last port served.
                grant_d = d_elig & (~i_elig | (last_owner == OWN_I));
                grant_i = i_elig & ~grant_d;
                if (grant_d | grant_i)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (mem_valid)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
                if (owner == OWN_D)
                    d_ack = 1'b1;
                else
                    // A flush in the completion cycle itself must also suppress the ack.
                    i_ack = ~cancel_flag & ~i_cancel;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= OWN_I;
            last_owner  <= OWN_I;
            cancel_flag <= 1'b0;
            lat_wr      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
        end else begin
            state <= state_nx;

            if (grant_d | grant_i) begin
                owner      <= grant_d ? OWN_D : OWN_I;
                last_owner <= grant_d ? OWN_D : OWN_I;
                lat_addr   <= grant_d ? d_addr : i_addr;
                lat_wr     <= grant_d & d_wr;
                lat_wdata  <= grant_d ? d_wdata : '0;
            end

            if (state_nx == S_IDLE)
                cancel_flag <= 1'b0;
            else if ((owner == OWN_I) && (state != S_IDLE) && i_cancel)
                cancel_flag <= 1'b1;

            // A cancelled fetch still lands in i_rdata; only its ack is dropped.
            if ((state == S_WAIT) && mem_valid && !lat_wr) begin
                if (owner == OWN_D)
                    d_rdata <= mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state == S_ISSUE);
    assign mem_wr    = lat_wr;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign busy      = (state != S_IDLE);

endmodule
